// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory port arbiter
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic P_MEM   = 1'b0;
    localparam logic P_LDR   = 1'b1;
    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;

    // Assemble the response word from the byte(s) read; byte reads zero-extend.
    function automatic logic [15:0] pack_rdata(input logic word, input logic [7:0] last_byte,
                                               input logic [7:0] low_byte);
        return (word == SZ_WORD) ? {last_byte, low_byte} : {8'h00, last_byte};
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - one requester port of the data-memory arbiter
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic              word;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              ack;
    logic              rsp_valid;
    logic [15:0]       rdata;

    modport master (output req, we, word, addr, wdata, input ack, rsp_valid, rdata);
    modport slave  (input req, we, word, addr, wdata, output ack, rsp_valid, rdata);
endinterface

// File: rtl/dmem_prio_arb.sv
// rtl/dmem_prio_arb.sv - fixed priority grant with starvation escape for the loader port
module dmem_prio_arb
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          force_ldr;

    assign force_ldr = (starve_cnt == CW'(STARVE_LIMIT));

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[P_LDR] && (force_ldr || !req[P_MEM])) begin
                gnt[P_LDR] = 1'b1;
            end else if (req[P_MEM]) begin
                gnt[P_MEM] = 1'b1;
            end
        end
    end

    // Counts only grants that the loader lost while it was asking; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (gnt[P_LDR]) begin
            starve_cnt <= '0;
        end else if (gnt[P_MEM] && req[P_LDR] && !force_ldr) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-port arbiter sequencing 8/16-bit accesses onto a byte-wide memory
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_port_arbiter_if.slave p0,
    dmem_port_arbiter_if.slave p1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);
    state_e            state_q, state_d;
    logic [1:0]        gnt;
    logic              arb_en;
    logic              sel_q, we_q, word_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        lo_q;
    logic [15:0]       rdata0_q, rdata1_q;
    logic [15:0]       rsp_data;
    logic              done;

    // Grants are suppressed while reset is held so no ack escapes during reset.
    assign arb_en = (state_q == IDLE) && rst_n;

    dmem_prio_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({p1.req, p0.req}),
        .gnt   (gnt)
    );

    always_comb begin
        state_d   = state_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = 8'h00;
        case (state_q)
            IDLE: begin
                if (|gnt) state_d = BEAT0;
            end
            BEAT0: begin
                mem_addr  = addr_q;
                mem_we    = we_q;
                mem_re    = !we_q;
                mem_wdata = we_q ? wdata_q[7:0] : 8'h00;
                state_d   = (word_q == SZ_WORD) ? BEAT1 : DONE;
            end
            BEAT1: begin
                mem_addr  = addr_q + ADDR_W'(1);
                mem_we    = we_q;
                mem_re    = !we_q;
                mem_wdata = we_q ? wdata_q[15:8] : 8'h00;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign done     = (state_q == DONE);
    assign rsp_data = we_q ? 16'h0000 : pack_rdata(word_q, mem_rdata, lo_q);
    assign busy     = (state_q != IDLE);

    assign p0.ack       = gnt[P_MEM];
    assign p1.ack       = gnt[P_LDR];
    assign p0.rsp_valid = done && (sel_q == P_MEM);
    assign p1.rsp_valid = done && (sel_q == P_LDR);
    assign p0.rdata     = p0.rsp_valid ? rsp_data : rdata0_q;
    assign p1.rdata     = p1.rsp_valid ? rsp_data : rdata1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= P_MEM;
            we_q     <= 1'b0;
            word_q   <= SZ_BYTE;
            addr_q   <= '0;
            wdata_q  <= 16'h0000;
            lo_q     <= 8'h00;
            rdata0_q <= 16'h0000;
            rdata1_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (|gnt) begin
                sel_q   <= gnt[P_LDR];
                we_q    <= gnt[P_LDR] ? p1.we    : p0.we;
                word_q  <= gnt[P_LDR] ? p1.word  : p0.word;
                addr_q  <= gnt[P_LDR] ? p1.addr  : p0.addr;
                wdata_q <= gnt[P_LDR] ? p1.wdata : p0.wdata;
            end
            // Low byte of a word read arrives the cycle after BEAT0's strobe.
            if (state_q == BEAT1 && !we_q) lo_q <= mem_rdata;
            if (done) begin
                if (sel_q == P_MEM) rdata0_q <= rsp_data;
                else                rdata1_q <= rsp_data;
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
    logic        clk;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        mem_clr;
    logic [7:0]  mem_arr [0:65535];
    int          total;
    int          bad;
    int          w;

    dmem_port_arbiter_if #(.ADDR_W(16)) p0_if ();
    dmem_port_arbiter_if #(.ADDR_W(16)) p1_if ();

    dmem_port_arbiter #(.ADDR_W(16), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p0_if),
        .p1        (p1_if),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 65536; i++) mem_arr[i] <= 8'h00;
            mem_arr[3] <= 8'h03;
        end else begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem_re ? mem_arr[mem_addr] : 8'h00;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int port, input logic req, input logic we, input logic word,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (port == 0) begin
            p0_if.req = req; p0_if.we = we; p0_if.word = word;
            p0_if.addr = addr; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.word = word;
            p1_if.addr = addr; p1_if.wdata = wdata;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        mem_clr = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_p0_rdata", p0_if.rdata, 16'h0000);
        chk("rst_p1_rsp", p1_if.rsp_valid, 0);
        mem_clr = 1'b0;
        rst_n = 1'b1;
        tick();

        // byte read at 0x0003
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000);
        #1;
        chk("br_ack", p0_if.ack, 1);
        chk("br_p1_ack", p1_if.ack, 0);
        tick();
        p0_if.req = 1'b0;
        #1;
        chk("br_re", mem_re, 1);
        chk("br_addr", mem_addr, 16'h0003);
        chk("br_busy", busy, 1);
        tick();
        chk("br_rsp", p0_if.rsp_valid, 1);
        chk("br_rdata", p0_if.rdata, 16'h0003);
        tick();
        chk("br_rsp_off", p0_if.rsp_valid, 0);
        chk("br_hold", p0_if.rdata, 16'h0003);
        chk("br_idle", busy, 0);

        // word write 0xBEEF at 0x0010
        drive(0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        #1;
        chk("ww_ack", p0_if.ack, 1);
        tick();
        p0_if.req = 1'b0;
        #1;
        chk("ww_we0", mem_we, 1);
        chk("ww_addr0", mem_addr, 16'h0010);
        chk("ww_data0", mem_wdata, 8'hEF);
        tick();
        chk("ww_we1", mem_we, 1);
        chk("ww_addr1", mem_addr, 16'h0011);
        chk("ww_data1", mem_wdata, 8'hBE);
        tick();
        chk("ww_rsp", p0_if.rsp_valid, 1);
        chk("ww_rdata", p0_if.rdata, 16'h0000);
        chk("ww_strobes", {mem_we, mem_re}, 2'b00);
        chk("ww_mem_lo", mem_arr[16'h0010], 8'hEF);
        tick();

        // word read back from 0x0010
        drive(0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
        #1;
        chk("wr_ack", p0_if.ack, 1);
        tick();
        p0_if.req = 1'b0;
        tick();
        chk("wr_re1", mem_re, 1);
        chk("wr_addr1", mem_addr, 16'h0011);
        tick();
        chk("wr_rsp", p0_if.rsp_valid, 1);
        chk("wr_rdata", p0_if.rdata, 16'hBEEF);
        tick();

        // word write wrapping past 0xFFFF
        drive(0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h1234);
        #1;
        chk("wrap_ack", p0_if.ack, 1);
        tick();
        p0_if.req = 1'b0;
        #1;
        chk("wrap_addr0", mem_addr, 16'hFFFF);
        chk("wrap_data0", mem_wdata, 8'h34);
        tick();
        chk("wrap_addr1", mem_addr, 16'h0000);
        chk("wrap_data1", mem_wdata, 8'h12);
        tick();
        chk("wrap_rsp", p0_if.rsp_valid, 1);
        chk("wrap_mem_ffff", mem_arr[16'hFFFF], 8'h34);
        chk("wrap_mem_0000", mem_arr[16'h0000], 8'h12);
        tick();

        // contention: both request continuously, expect 4x p0 then 1x p1
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000);
        drive(1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        #1;
        for (int g = 0; g < 10; g++) begin
            w = 0;
            while (!(p0_if.ack || p1_if.ack) && w < 8) begin
                tick();
                w++;
            end
            chk("cont_timeout", (w < 8), 1);
            chk("cont_gap", w, (g == 0) ? 0 : 2);
            chk("cont_both", p0_if.ack & p1_if.ack, 0);
            chk("cont_winner", p1_if.ack, ((g % 5) == 4) ? 1 : 0);
            tick();
        end
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        tick();
        chk("cont_idle", busy, 0);

        // reset during BEAT1 of a word write
        drive(0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'hA55A);
        #1;
        chk("rw_ack", p0_if.ack, 1);
        tick();
        p0_if.req = 1'b0;
        tick();
        chk("rw_beat1_we", mem_we, 1);
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000);
        #1;
        chk("rw_we_drop", mem_we, 0);
        chk("rw_busy", busy, 0);
        chk("rw_rsp", p0_if.rsp_valid, 0);
        chk("rw_ack_in_rst", p0_if.ack, 0);
        tick();
        chk("rw_rsp_later", p0_if.rsp_valid, 0);
        chk("rw_ack_later", p0_if.ack, 0);
        chk("rw_lo_kept", mem_arr[16'h0020], 8'h5A);
        chk("rw_hi_untouched", mem_arr[16'h0021], 8'h00);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rw_first_ack", p0_if.ack, 1);
        tick();
        p0_if.req = 1'b0;
        tick();
        chk("rw_rsp_after", p0_if.rsp_valid, 1);
        chk("rw_rdata_after", p0_if.rdata, 16'h0003);
        tick();

        // back-to-back byte reads on p1, p0 idle
        drive(1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        #1;
        chk("b2b_ack0", p1_if.ack, 1);
        tick();
        chk("b2b_re0", mem_re, 1);
        chk("b2b_we0", mem_we, 0);
        chk("b2b_noack0", p1_if.ack, 0);
        tick();
        chk("b2b_rsp0", p1_if.rsp_valid, 1);
        chk("b2b_rdata0", p1_if.rdata, 16'h00EF);
        chk("b2b_p0_rsp", p0_if.rsp_valid, 0);
        tick();
        chk("b2b_pulse0", p1_if.rsp_valid, 0);
        p1_if.addr = 16'h0011;
        #1;
        chk("b2b_ack1", p1_if.ack, 1);
        tick();
        chk("b2b_we1", mem_we, 0);
        tick();
        chk("b2b_rsp1", p1_if.rsp_valid, 1);
        chk("b2b_rdata1", p1_if.rdata, 16'h00BE);
        tick();
        chk("b2b_pulse1", p1_if.rsp_valid, 0);
        p1_if.req = 1'b0;
        #1;
        chk("b2b_noack_end", p1_if.ack, 0);
        chk("b2b_hold", p1_if.rdata, 16'h00BE);
        chk("b2b_p0_hold", p0_if.rdata, 16'h0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
